mux8_scan_ctrl: RTL and testbench

- Sequential select generator that sits directly upstream of the 8:1 case-statement mux (mux8).
- Drives the mux select, steps through all 8 inputs, samples the mux output for each, and assembles one 8-bit frame.
- Presents the frame on a valid/ready output handshake.
- Replaces manual select stepping with a repeatable, timed scan.

---
 rtl/mux8_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_mux8_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_scan_ctrl.sv
// Scan controller for the mux8 select: steps sel over all 8 channels, samples
// mux_y after a configurable dwell, and hands the assembled frame out on valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; sel parked at 0
// SCAN  | stepping sel 0..7, DWELL cycles per channel, capturing mux_y
// HOLD  | frame presented on data with valid=1 until ready
module mux8_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mux_y,
    input  logic       ready,
    output logic [2:0] sel,
    output logic       busy,
    output logic [7:0] data,
    output logic       valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_sel,   w_sel_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [7:0] r_cap,   w_cap_nxt;
    logic [7:0] r_data,  w_data_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_busy,  w_busy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 3'd0;
            r_cnt   <= 4'd0;
            r_cap   <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cap   <= w_cap_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SCAN;
                    w_sel_nxt   = 3'd0;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_SCAN: begin
                if (r_cnt == CNT_LAST) begin
                    w_cap_nxt[r_sel] = mux_y;
                    w_cnt_nxt        = 4'd0;
                    if (r_sel == 3'd7) begin
                        // Last channel goes straight into the frame; r_cap[7] is not yet updated.
                        w_data_nxt  = {mux_y, r_cap[6:0]};
                        w_sel_nxt   = 3'd0;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_sel_nxt = r_sel + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_HOLD: begin
                if (ready) begin
                    w_valid_nxt = 1'b0;
                    if (start) begin
                        w_state_nxt = S_SCAN;
                        w_sel_nxt   = 3'd0;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = 3'd0;
                w_cnt_nxt   = 4'd0;
                w_valid_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_SCAN);
    end

    assign sel   = r_sel;
    assign busy  = r_busy;
    assign data  = r_data;
    assign valid = r_valid;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: a behavioural mux8 (mux_y = pattern[sel])
// feeds a DWELL=2 instance and a DWELL=1 instance; expected values are hand-derived.
module tb_mux8_scan_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start, ready, mux_y, busy, valid;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] pattern;

    logic       start1, ready1, mux_y1, busy1, valid1;
    logic [2:0] sel1;
    logic [7:0] data1;
    logic [7:0] pattern1;

    int n_checks;
    int n_fail;
    int cyc;
    logic overlap_seen;

    mux8_scan_ctrl #(.DWELL(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mux_y (mux_y),
        .ready (ready),
        .sel   (sel),
        .busy  (busy),
        .data  (data),
        .valid (valid)
    );

    mux8_scan_ctrl #(.DWELL(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .mux_y (mux_y1),
        .ready (ready1),
        .sel   (sel1),
        .busy  (busy1),
        .data  (data1),
        .valid (valid1)
    );

    assign mux_y  = pattern[sel];
    assign mux_y1 = pattern1[sel1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid && busy) overlap_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until valid (DWELL=2 instance) or budget expires.
    task automatic wait_valid(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) seen = valid;
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int t1, t2, n_frames;
        logic busy_seen, valid_seen;

        n_checks = 0; n_fail = 0; cyc = 0; overlap_seen = 1'b0;
        rst_n = 1'b0;
        start = 1'b0; ready = 1'b1; pattern = 8'h00;
        start1 = 1'b0; ready1 = 1'b1; pattern1 = 8'h00;
        #23;
        check("rst_sel",   32'(sel),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data",  32'(data),  32'h00);
        rst_n = 1'b1;
        tick();
        tick();

        // 1: basic scan, DWELL=2, pattern A5
        pattern = 8'hA5;
        check("t1_idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t1_sel_%0d", i), 32'(sel), 32'(i / 2));
            check($sformatf("t1_busy_%0d", i), 32'(busy), 32'd1);
            check($sformatf("t1_valid_%0d", i), 32'(valid), 32'd0);
            tick();
        end
        check("t1_valid_rise", 32'(valid), 32'd1);
        check("t1_data",       32'(data),  32'hA5);
        check("t1_busy_off",   32'(busy),  32'd0);
        check("t1_sel_home",   32'(sel),   32'd0);
        tick();
        check("t1_valid_1cyc", 32'(valid), 32'd0);
        check("t1_busy_idle",  32'(busy),  32'd0);
        check("t1_data_keep",  32'(data),  32'hA5);

        // 2: backpressure, start pulses in HOLD ignored
        pattern = 8'h3C;
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("t2_valid_timeout", 40);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_hold_valid_%0d", i), 32'(valid), 32'd1);
            check($sformatf("t2_hold_data_%0d", i),  32'(data),  32'h3C);
            check($sformatf("t2_hold_busy_%0d", i),  32'(busy),  32'd0);
            if (i == 2) start = 1'b1;
            if (i == 4) start = 1'b0;
            tick();
        end
        check("t2_still_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        tick();
        check("t2_hs_valid", 32'(valid), 32'd0);
        check("t2_hs_busy",  32'(busy),  32'd0);
        busy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy || valid) busy_seen = 1'b1;
            tick();
        end
        check("t2_stays_idle", 32'(busy_seen), 32'd0);

        // 4: asynchronous reset while sel==4
        pattern = 8'hE7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t4_sel_pre", 32'(sel), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_sel",   32'(sel),   32'd0);
        check("t4_rst_busy",  32'(busy),  32'd0);
        check("t4_rst_valid", 32'(valid), 32'd0);
        check("t4_rst_data",  32'(data),  32'h00);
        #3;
        rst_n = 1'b1;
        valid_seen = 1'b0;
        busy_seen  = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (valid) valid_seen = 1'b1;
            if (busy)  busy_seen  = 1'b1;
        end
        check("t4_no_valid", 32'(valid_seen), 32'd0);
        check("t4_no_busy",  32'(busy_seen),  32'd0);

        // 3: back-to-back frames, start and ready held high
        overlap_seen = 1'b0;
        pattern = 8'hFF;
        ready = 1'b1;
        start = 1'b1;
        tick();
        wait_valid("t3_valid1_timeout", 40);
        t1 = cyc;
        check("t3_data1", 32'(data), 32'hFF);
        pattern = 8'h00;
        tick();
        check("t3_rescan_busy",  32'(busy),  32'd1);
        check("t3_rescan_valid", 32'(valid), 32'd0);
        check("t3_rescan_sel",   32'(sel),   32'd0);
        wait_valid("t3_valid2_timeout", 40);
        t2 = cyc;
        check("t3_data2",   32'(data),   32'h00);
        check("t3_spacing", 32'(t2 - t1), 32'd17);
        start = 1'b0;
        tick();
        check("t3_end_valid", 32'(valid), 32'd0);
        check("t3_end_busy",  32'(busy),  32'd0);
        check("t3_no_overlap", 32'(overlap_seen), 32'd0);

        // 5: start pulse at sel==3 is ignored
        pattern = 8'h81;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t5_sel_at_pulse", 32'(sel), 32'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("t5_valid_timeout", 40);
        check("t5_data", 32'(data), 32'h81);
        n_frames = 0;
        busy_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) busy_seen = 1'b1;
            if (valid) n_frames++;
        end
        check("t5_no_rescan", 32'(busy_seen), 32'd0);
        check("t5_one_frame", 32'(n_frames),  32'd0);

        // 6: DWELL=1 instance, pattern 5A
        pattern1 = 8'h5A;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6_sel_%0d", i),  32'(sel1),   32'(i));
            check($sformatf("t6_busy_%0d", i), 32'(busy1),  32'd1);
            check($sformatf("t6_valid_%0d", i), 32'(valid1), 32'd0);
            tick();
        end
        check("t6_valid", 32'(valid1), 32'd1);
        check("t6_data",  32'(data1),  32'h5A);
        check("t6_busy_off", 32'(busy1), 32'd0);
        tick();
        check("t6_valid_drop", 32'(valid1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
